vga_sync_monitor: RTL and testbench

Receive-side checker for the VGA timing the display controller transmits. It samples `hSync`/`vSync` on the 25 MHz pixel strobe and rebuilds sync-relative `hCount`/`vCount` from the sync edges alone. It checks every line and frame against the configured 640x480 geometry and reports lock state, error pulses and a saturating error count, which the top level can route to the seven-segment display. It sits beside the display controller on the board clock and taps only its sync outputs.

---
 rtl/vga_sync_monitor.sv | 182 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - rebuilds VGA h/v counters from sync edges, checks geometry, tracks lock
// Define VGA_SYNC_MON_ERRCNT_EN to build the saturating errCount register; otherwise errCount is 0.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixEn,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       lineStart,
  output logic       frameStart,
  output logic       locked,
  output logic       hErr,
  output logic       vErr,
  output logic [7:0] errCount
);

  localparam logic [10:0] H_TOT     = 11'(H_TOTAL);
  localparam logic [10:0] H_PER_MAX = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_SYN     = 11'(H_SYNC);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [10:0] V_TOT     = 11'(V_TOTAL);
  localparam logic [10:0] V_SYN     = 11'(V_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
  localparam logic [10:0] SAT11     = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state;
  logic        hs_q, vs_q, smp_ok, h_prim, v_prim, skip_frame;
  logic [10:0] h_per, h_wid, v_lines, v_wid;
  logic [3:0]  good;

  logic hs_act, vs_act, hs_q_act, vs_q_act;
  logic hs_lead, hs_trail, vs_lead, vs_trail;
  logic h_tmo, h_fail, v_fail, any_err;

  always_comb begin
    hs_act   = (hSync == SYNC_POL);
    vs_act   = (vSync == SYNC_POL);
    hs_q_act = (hs_q == SYNC_POL);
    vs_q_act = (vs_q == SYNC_POL);
    hs_lead  = pixEn &&  hs_act && !hs_q_act;
    hs_trail = pixEn && !hs_act &&  hs_q_act;
    vs_lead  = pixEn &&  vs_act && !vs_q_act;
    vs_trail = pixEn && !vs_act &&  vs_q_act;
    h_tmo    = pixEn && !hs_lead && (h_per == H_PER_MAX - 11'd1);
    h_fail   = (hs_lead  && h_prim && (h_per + 11'd1 != H_TOT)) ||
               (hs_trail && h_prim && (h_wid != H_SYN)) || h_tmo;
    v_fail   = (vs_lead  && v_prim && (v_lines != V_TOT)) ||
               (vs_trail && v_prim && (v_wid != V_SYN));
    any_err  = h_fail || v_fail;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      smp_ok     <= 1'b0;
      h_prim     <= 1'b0;
      v_prim     <= 1'b0;
      skip_frame <= 1'b0;
      h_per      <= '0;
      h_wid      <= '0;
      v_lines    <= '0;
      v_wid      <= '0;
      good       <= '0;
      state      <= SEARCH;
      hCount     <= '0;
      vCount     <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      locked     <= 1'b0;
      hErr       <= 1'b0;
      vErr       <= 1'b0;
    end else begin
      lineStart  <= hs_lead;
      frameStart <= vs_lead;
      hErr       <= h_fail;
      vErr       <= v_fail;
      if (pixEn) begin
        hs_q   <= hSync;
        vs_q   <= vSync;
        smp_ok <= 1'b1;
      end

      if (hs_lead) begin
        h_per  <= '0;
        h_wid  <= 11'd1;
        hCount <= '0;
      end else if (pixEn) begin
        if (h_per != H_PER_MAX) h_per <= h_per + 11'd1;
        if (hs_act && hs_q_act && h_wid != SAT11) h_wid <= h_wid + 11'd1;
        if (hCount != H_LAST) hCount <= hCount + 10'd1;
      end

      // An hsync edge coincident with the vsync edge opens the new frame.
      if (vs_lead) begin
        v_lines <= {10'd0, hs_lead};
        v_wid   <= {10'd0, hs_lead};
        vCount  <= '0;
      end else if (hs_lead) begin
        if (v_lines != SAT11) v_lines <= v_lines + 11'd1;
        if (vs_act && vs_q_act && v_wid != SAT11) v_wid <= v_wid + 11'd1;
        if (vCount != V_LAST) vCount <= vCount + 10'd1;
      end

      // Edges seen on the very first strobe after reset only reflect the reset level of hs_q/vs_q.
      if (hs_lead && smp_ok) h_prim <= 1'b1;
      if (vs_lead && smp_ok) v_prim <= 1'b1;

      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_lead && smp_ok) begin
            state      <= ACQUIRE;
            good       <= '0;
            skip_frame <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (any_err) begin
            state  <= SEARCH;
            locked <= 1'b0;
            h_prim <= 1'b0;
            v_prim <= 1'b0;
          end else if (vs_lead) begin
            if (skip_frame) begin
              skip_frame <= 1'b0;
              locked     <= 1'b0;
            end else begin
              good   <= good + 4'd1;
              locked <= (good + 4'd1 == LOCK_N);
              if (good + 4'd1 == LOCK_N) state <= LOCKED;
            end
          end else begin
            locked <= 1'b0;
          end
        end
        LOCKED: begin
          locked <= !any_err;
          if (any_err) begin
            // A mid-frame failure leaves a partial frame that must not count as clean.
            state      <= ACQUIRE;
            good       <= '0;
            skip_frame <= !vs_lead;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_MON_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_cnt <= '0;
    end else if (any_err && state != SEARCH && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign errCount = err_cnt;
`else
  assign errCount = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed self-checking bench for vga_sync_monitor on a reduced 20x10 geometry
module tb_vga_sync_monitor;

  localparam int H  = 20;
  localparam int HS = 4;
  localparam int V  = 10;
  localparam int VS = 2;
  localparam int LF = 2;
  localparam bit POL = 1'b0;
`ifdef VGA_SYNC_MON_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       Clk   = 1'b0;
  logic       Reset = 1'b0;
  logic       pixEn = 1'b0;
  logic       hSync = ~POL;
  logic       vSync = ~POL;
  logic [9:0] hCount, vCount;
  logic       lineStart, frameStart, locked, hErr, vErr;
  logic [7:0] errCount;

  int checks = 0;
  int errors = 0;
  int herr_seen = 0;
  int verr_seen = 0;
  bit gap = 1'b0;

  always #5 Clk = ~Clk;

  vga_sync_monitor #(
    .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V), .V_SYNC(VS), .LOCK_FRAMES(LF), .SYNC_POL(POL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pixEn(pixEn), .hSync(hSync), .vSync(vSync),
    .hCount(hCount), .vCount(vCount), .lineStart(lineStart), .frameStart(frameStart),
    .locked(locked), .hErr(hErr), .vErr(vErr), .errCount(errCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ecnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic idle();
    pixEn = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic strobe(input bit h, input bit v);
    if (gap) idle();
    hSync = h ? POL : ~POL;
    vSync = v ? POL : ~POL;
    pixEn = 1'b1;
    @(posedge Clk);
    #1;
    herr_seen += int'(hErr);
    verr_seen += int'(vErr);
  endtask

  task automatic line(input int from, input int to, input bit v);
    for (int i = from; i < to; i++) strobe(i < HS, v);
  endtask

  task automatic lines(input int l0, input int l1, input int vw);
    for (int l = l0; l < l1; l++) line(0, H, l < vw);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_hCount", 32'(hCount), 0);
    chk("rst_vCount", 32'(vCount), 0);
    chk("rst_lineStart", 32'(lineStart), 0);
    chk("rst_frameStart", 32'(frameStart), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_hErr", 32'(hErr), 0);
    chk("rst_vErr", 32'(vErr), 0);
    chk("rst_errCount", 32'(errCount), 0);
    Reset = 1'b0;

    // nominal acquisition
    repeat (5) strobe(1'b0, 1'b0);
    lines(0, V, VS);
    chk("f1_locked", 32'(locked), 0);
    lines(0, V, VS);
    chk("f2_locked", 32'(locked), 0);
    chk("vcount_before_wrap", 32'(vCount), V - 1);
    strobe(1'b1, 1'b1);
    chk("lock_rise", 32'(locked), 1);
    chk("f3_frameStart", 32'(frameStart), 1);
    chk("f3_lineStart", 32'(lineStart), 1);
    chk("f3_hCount0", 32'(hCount), 0);
    chk("f3_vCount0", 32'(vCount), 0);
    line(1, HS, 1'b1);
    chk("hcount_at_trail", 32'(hCount), HS - 1);
    strobe(1'b0, 1'b1);
    chk("htrail_no_err", 32'(hErr), 0);
    line(HS + 1, H, 1'b1);
    chk("hcount_line_end", 32'(hCount), H - 1);
    chk("nominal_errCount", 32'(errCount), 0);

    // one short line while locked
    herr_seen = 0;
    verr_seen = 0;
    line(0, H - 1, 1'b1);
    strobe(1'b1, 1'b0);
    chk("short_hErr", 32'(hErr), 1);
    chk("short_no_vErr", 32'(vErr), 0);
    chk("short_locked_fall", 32'(locked), 0);
    chk("short_errCount", 32'(errCount), ecnt(1));
    line(1, H, 1'b0);
    lines(3, V, VS);
    lines(0, V, VS);
    chk("relock_f4", 32'(locked), 0);
    lines(0, V, VS);
    chk("relock_f5", 32'(locked), 0);
    lines(0, V, VS);
    chk("relock_f6", 32'(locked), 1);
    chk("short_hErr_pulses", 32'(herr_seen), 1);
    chk("short_vErr_pulses", 32'(verr_seen), 0);

    // vsync three lines wide while locked
    herr_seen = 0;
    verr_seen = 0;
    lines(0, 3, 3);
    strobe(1'b1, 1'b0);
    chk("vwid_vErr", 32'(vErr), 1);
    chk("vwid_locked_fall", 32'(locked), 0);
    chk("vwid_errCount", 32'(errCount), ecnt(2));
    line(1, H, 1'b0);
    lines(4, V, VS);

    // relock with a dead cycle before every strobe
    gap = 1'b1;
    strobe(1'b1, 1'b1);
    chk("gap_frameStart", 32'(frameStart), 1);
    idle();
    chk("gap_frameStart_pulse", 32'(frameStart), 0);
    chk("gap_lineStart_pulse", 32'(lineStart), 0);
    chk("gap_hCount_hold", 32'(hCount), 0);
    line(1, H, 1'b1);
    lines(1, V, VS);
    chk("gap_f8_locked", 32'(locked), 0);
    lines(0, V, VS);
    chk("gap_f9_locked", 32'(locked), 0);
    lines(0, V, VS);
    chk("gap_f10_locked", 32'(locked), 1);
    gap = 1'b0;
    chk("vwid_hErr_pulses", 32'(herr_seen), 0);
    chk("vwid_vErr_pulses", 32'(verr_seen), 1);

    // frame one line short
    lines(0, V - 1, VS);
    strobe(1'b1, 1'b1);
    chk("vlines_vErr", 32'(vErr), 1);
    chk("vlines_no_hErr", 32'(hErr), 0);
    chk("vlines_locked_fall", 32'(locked), 0);
    chk("vlines_errCount", 32'(errCount), ecnt(3));

    // hsync stops: one timeout at 2*H strobes after the last leading edge
    herr_seen = 0;
    line(1, 2 * H, 1'b1);
    chk("tmo_none_early", 32'(herr_seen), 0);
    chk("tmo_hCount_sat", 32'(hCount), H - 1);
    strobe(1'b0, 1'b1);
    chk("tmo_hErr", 32'(hErr), 1);
    chk("tmo_errCount", 32'(errCount), ecnt(4));
    herr_seen = 0;
    repeat (60) strobe(1'b0, 1'b1);
    chk("tmo_single_pulse", 32'(herr_seen), 0);
    chk("tmo_hCount_hold", 32'(hCount), H - 1);

    // recover, then reset mid-frame with hsync asserted
    herr_seen = 0;
    verr_seen = 0;
    strobe(1'b0, 1'b0);
    lines(0, V, VS);
    lines(0, V, VS);
    lines(0, V, VS);
    chk("recover_locked", 32'(locked), 1);
    chk("recover_no_errs", 32'(herr_seen + verr_seen), 0);
    lines(0, 4, VS);
    line(0, 2, 1'b0);
    chk("pre_rst_hCount", 32'(hCount), 1);
    chk("pre_rst_vCount", 32'(vCount), 4);
    #3 Reset = 1'b1;
    #1;
    chk("arst_hCount", 32'(hCount), 0);
    chk("arst_vCount", 32'(vCount), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_errCount", 32'(errCount), 0);
    chk("arst_lineStart", 32'(lineStart), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    herr_seen = 0;
    verr_seen = 0;
    line(2, H, 1'b0);
    lines(5, V, VS);
    lines(0, V, VS);
    chk("post_rst_p_locked", 32'(locked), 0);
    lines(0, V, VS);
    chk("post_rst_q_locked", 32'(locked), 0);
    lines(0, V, VS);
    chk("post_rst_relock", 32'(locked), 1);
    chk("post_rst_hErr_pulses", 32'(herr_seen), 0);
    chk("post_rst_vErr_pulses", 32'(verr_seen), 0);
    chk("post_rst_errCount", 32'(errCount), 0);

    // 300 injected error events: simultaneous h and v width failures right after acquisition
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b0);
    chk("inj_hErr", 32'(hErr), 1);
    chk("inj_vErr", 32'(vErr), 1);
    chk("inj_one_event", 32'(errCount), ecnt(1));
    repeat (9) begin
      strobe(1'b1, 1'b1);
      strobe(1'b0, 1'b0);
    end
    chk("inj_10", 32'(errCount), ecnt(10));
    repeat (290) begin
      strobe(1'b1, 1'b1);
      strobe(1'b0, 1'b0);
    end
    chk("inj_300_sat", 32'(errCount), ecnt(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
